// File: rtl/tt_io_exerciser.sv
// tt_io_exerciser: LFSR stimulus driver with MISR response compaction.
// Define TT_EXERCISER_CONT_EN for back-to-back runs and fail_sticky.
module tt_io_exerciser #(
  parameter int NUM_VECTORS = 64,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [7:0]  seed,
  input  logic [15:0] golden,
  output logic [7:0]  stim_out,
  input  logic [7:0]  resp_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
`ifdef TT_EXERCISER_CONT_EN
  ,
  input  logic        cont,
  output logic        fail_sticky
`endif
);

  localparam int CW =
    (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [CW-1:0] VLAST =
    CW'(NUM_VECTORS - 1);
  localparam logic [3:0] DLAST =
    4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_nxt;
  logic [7:0]    eff_seed;
  logic [15:0]   misr;
  logic [15:0]   misr_nxt;
  logic [15:0]   misr_fin;
  logic [CW-1:0] vcnt;
  logic [3:0]    dcnt;
  logic          last;
  logic          cap;
  logic          launch;
  logic          relaunch;
  logic          to_done;

  assign eff_seed = (seed == 8'h00) ? 8'h01 : seed;
  assign lfsr_nxt = {lfsr[6:0],
                     lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_nxt = {misr[14:0],
                     misr[15] ^ misr[14] ^ misr[12] ^ misr[3]}
                    ^ {8'h00, resp_in};
  assign misr_fin = cap ? misr_nxt : misr;
  assign last     = (vcnt == VLAST);
  assign to_done  = (state != DONE) && (state_nxt == DONE);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Capture strobe: each RUN cycle's vector lands LATENCY cycles later
  generate
    if (LATENCY == 0) begin : g_nolat
      assign cap = (state == RUN);
    end else begin : g_lat
      logic [LATENCY-1:0] vpipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe <= '0;
        end else if (ena) begin
          vpipe <= LATENCY'({vpipe, state == RUN});
        end
      end
      assign cap = vpipe[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    relaunch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          launch    = 1'b1;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = (LATENCY == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt == DLAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
`ifdef TT_EXERCISER_CONT_EN
        if (cont) begin
          state_nxt = RUN;
          relaunch  = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= 8'h00;
      stim_out  <= 8'h00;
      misr      <= 16'h0000;
      vcnt      <= '0;
      dcnt      <= 4'd0;
      pass      <= 1'b0;
      signature <= 16'h0000;
    end else if (ena) begin
      if (cap) begin
        misr <= misr_nxt;
      end
      unique case (state)
        IDLE: begin
          if (launch) begin
            lfsr      <= eff_seed;
            stim_out  <= eff_seed;
            misr      <= 16'h0000;
            vcnt      <= '0;
            dcnt      <= 4'd0;
            pass      <= 1'b0;
            signature <= 16'h0000;
          end
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          if (!last) begin
            stim_out <= lfsr_nxt;
            vcnt     <= vcnt + 1'b1;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 4'd1;
        end
        DONE: begin
          // Chained run seeds from where the LFSR stopped
          if (relaunch) begin
            stim_out <= lfsr;
            misr     <= 16'h0000;
            vcnt     <= '0;
            dcnt     <= 4'd0;
          end else begin
            stim_out <= 8'h00;
          end
        end
        default: ;
      endcase
      if (to_done) begin
        signature <= misr_fin;
        pass      <= (misr_fin == golden);
      end
    end
  end

`ifdef TT_EXERCISER_CONT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_sticky <= 1'b0;
    end else if (ena) begin
      if (launch) begin
        fail_sticky <= 1'b0;
      end else if (to_done && (misr_fin != golden)) begin
        fail_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tt_io_exerciser.sv
// tb_tt_io_exerciser: random runs on two configurations
// against a vector/signature reference model.
module tb_tt_io_exerciser;

  localparam int NA = 3;
  localparam int LA = 0;
  localparam int NB = 6;
  localparam int LB = 2;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [7:0]  seed;
  logic [15:0] golden_a;
  logic [15:0] golden_b;
  logic [7:0]  stim_a;
  logic [7:0]  stim_b;
  logic [7:0]  resp_a;
  logic [7:0]  resp_b;
  logic        busy_a;
  logic        busy_b;
  logic        done_a;
  logic        done_b;
  logic        pass_a;
  logic        pass_b;
  logic [15:0] sig_a;
  logic [15:0] sig_b;
  logic        md_a;
  logic        md_b;
  logic [7:0]  k_a;
  logic [7:0]  k_b;
  logic [7:0]  d1 = 8'h00;
  logic [7:0]  d2 = 8'h00;
  int          checks = 0;
  int          errors = 0;

  tt_io_exerciser #(
    .NUM_VECTORS(NA),
    .LATENCY(LA)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .start(start), .seed(seed), .golden(golden_a),
    .stim_out(stim_a), .resp_in(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a)
  );

  tt_io_exerciser #(
    .NUM_VECTORS(NB),
    .LATENCY(LB)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .start(start), .seed(seed), .golden(golden_b),
    .stim_out(stim_b), .resp_in(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b)
  );

  // Far-side DUTs: direct loopback and a 2-register loopback
  assign resp_a = md_a ? k_a : (stim_a ^ k_a);
  assign resp_b = md_b ? k_b : (d2 ^ k_b);

  always @(posedge clk) begin
    if (ena) begin
      d1 <= stim_b;
      d2 <= d1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] vec_at(input logic [7:0] sd,
                                        input int k);
    int unsigned s;
    s = (sd == 8'h00) ? 1 : sd;
    for (int i = 0; i < k; i++) begin
      s = ((s << 1) & 32'hFE) |
          (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1);
    end
    return 8'(s);
  endfunction

  function automatic logic [15:0] sig_model(input logic [7:0] sd,
                                            input int n,
                                            input logic md,
                                            input logic [7:0] k);
    int unsigned m;
    int unsigned r;
    int unsigned fb;
    m = 0;
    for (int i = 0; i < n; i++) begin
      r  = md ? k : (vec_at(sd, i) ^ k);
      fb = ((m >> 15) ^ (m >> 14) ^ (m >> 12) ^ (m >> 3)) & 1;
      m  = (((m << 1) | fb) & 32'hFFFF) ^ r;
    end
    return 16'(m);
  endfunction

  task automatic chk_inst(input string nm, input int c,
                          input int n, input int l,
                          input logic [7:0] stim,
                          input logic bsy, input logic dn,
                          input logic ps, input logic [15:0] sg,
                          input logic [15:0] es,
                          input logic [15:0] gd);
    logic [7:0] ev;
    if (c < n) ev = vec_at(seed, c);
    else if (c <= n + l) ev = vec_at(seed, n - 1);
    else ev = 8'h00;
    check($sformatf("%s_stim_c%0d", nm, c), stim, ev);
    check($sformatf("%s_busy_c%0d", nm, c), bsy, c < n + l);
    check($sformatf("%s_done_c%0d", nm, c), dn, c == n + l);
    if (c == n + l) begin
      check($sformatf("%s_sig", nm), sg, es);
      check($sformatf("%s_pass", nm), ps, es == gd);
    end
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_a_stim0"}, stim_a, 0);
    check({nm, "_a_busy0"}, busy_a, 0);
    check({nm, "_a_done0"}, done_a, 0);
    check({nm, "_a_pass0"}, pass_a, 0);
    check({nm, "_a_sig0"}, sig_a, 0);
    check({nm, "_b_stim0"}, stim_b, 0);
    check({nm, "_b_busy0"}, busy_b, 0);
    check({nm, "_b_done0"}, done_b, 0);
    check({nm, "_b_pass0"}, pass_b, 0);
    check({nm, "_b_sig0"}, sig_b, 0);
  endtask

  // fmode: 0 none, 1 five-cycle freeze at cycle 2, 2 random ena
  task automatic run(input int fmode, input bit kick,
                     input bit rst_mid, input bit ga,
                     input bit gb);
    logic [15:0] sa;
    logic [15:0] sb;
    int c;
    int it;
    int fleft;
    sa = sig_model(seed, NA, md_a, k_a);
    sb = sig_model(seed, NB, md_b, k_b);
    golden_a = ga ? sa : 16'($urandom);
    golden_b = gb ? sb : 16'($urandom);
    ena   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c     = 0;
    it    = 0;
    fleft = 5;
    while (c <= NB + LB + 1) begin
      chk_inst("a", c, NA, LA, stim_a, busy_a, done_a,
               pass_a, sig_a, sa, golden_a);
      chk_inst("b", c, NB, LB, stim_b, busy_b, done_b,
               pass_b, sig_b, sb, golden_b);
      if (rst_mid && c == 2) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_a_nodone", done_a, 0);
        check("arst_b_nodone", done_b, 0);
        check("arst_b_idle", busy_b, 0);
        return;
      end
      ena = 1'b1;
      if (fmode == 1 && c == 2 && fleft > 0) begin
        ena = 1'b0;
        fleft--;
      end else if (fmode == 2) begin
        ena = ($urandom_range(0, 3) != 0);
      end
      start = kick && (c == 1);
      @(negedge clk);
      start = 1'b0;
      if (ena) c++;
      it++;
      if (it > 200) begin
        check("loop_bound", it, 200);
        break;
      end
    end
    ena = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b0;
    start    = 1'b0;
    seed     = 8'h00;
    golden_a = 16'h0000;
    golden_b = 16'h0000;
    md_a     = 1'b0;
    md_b     = 1'b0;
    k_a      = 8'h00;
    k_b      = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);

    seed = 8'h01;
    run(0, 0, 0, 1, 1);
    seed = 8'h00;
    run(0, 0, 0, 0, 1);
    md_a = 1'b1;
    k_a  = 8'hFF;
    md_b = 1'b1;
    k_b  = 8'hFF;
    seed = 8'h5A;
    run(0, 0, 0, 0, 0);
    md_a = 1'b0;
    k_a  = 8'h00;
    md_b = 1'b0;
    k_b  = 8'h00;
    seed = 8'h3C;
    run(1, 1, 0, 1, 1);
    seed = 8'hA7;
    run(0, 0, 1, 1, 1);
    run(0, 0, 0, 1, 1);

    for (int r = 0; r < 20; r++) begin
      seed = 8'($urandom);
      md_a = 1'($urandom);
      md_b = 1'($urandom);
      k_a  = 8'($urandom);
      k_b  = 8'($urandom);
      run(int'($urandom_range(0, 2)), 1'($urandom), 0,
          1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
